pu_loader: RTL

Feeder for the img2col processing unit: accepts a load command and a two-pixel-per-beat input stream, then drives the PU's dual write port (`new1`/`new2`, `adrs_in1`/`adrs_in2`) together with `start` and `round`. A full load (`round`=0) writes all 25 window pixels. A sliding load (`round`=1) writes only the 5 new-column pixels at addresses 20..24; the PU's reserved registers supply the other 20. The block sits between the AXI-side input buffer and one PU.

---
 rtl/pu_loader.sv | 111 +++++++++++
 1 files changed

// File: rtl/pu_loader.sv
// Feeds one img2col PU from a two-pixel-per-beat stream.
// A full load writes all 25 window registers; a sliding load writes only the 5 new-column registers.
//
// state | meaning
// IDLE  | waiting for a load command; cmd_ready high
// LOAD  | accepting pixel-pair beats; s_ready high
module pu_loader #(
   parameter int DATA_WIDTH  = 16,
   parameter int WEIGHT_SIZE = 25,
   parameter int ADDRESS_NUM = 5,
   parameter int REG_NUM     = 20
) (
   input  logic                    i_clk,
   input  logic                    i_nrst,
   input  logic                    i_cmd_valid,
   input  logic                    i_cmd_round,
   output logic                    o_cmd_ready,
   input  logic                    i_s_valid,
   input  logic [2*DATA_WIDTH-1:0] i_s_data,
   output logic                    o_s_ready,
   output logic [DATA_WIDTH-1:0]   o_new1,
   output logic [DATA_WIDTH-1:0]   o_new2,
   output logic [ADDRESS_NUM-1:0]  o_adrs_in1,
   output logic [ADDRESS_NUM-1:0]  o_adrs_in2,
   output logic                    o_start,
   output logic                    o_round,
   output logic                    o_done
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOAD = 1'b1;

   // Final beat index: odd pixel counts leave a half-filled last beat.
   localparam logic [3:0] LAST_FULL  = 4'((WEIGHT_SIZE - 1) / 2);
   localparam logic [3:0] LAST_SLIDE = 4'((WEIGHT_SIZE - REG_NUM - 1) / 2);
   localparam logic [ADDRESS_NUM-1:0] BASE_SLIDE = ADDRESS_NUM'(REG_NUM);

   logic [0:0]             r_state;
   logic [3:0]             r_k;
   logic                   r_round;
   logic [DATA_WIDTH-1:0]  r_new1;
   logic [DATA_WIDTH-1:0]  r_new2;
   logic [ADDRESS_NUM-1:0] r_adr1;
   logic [ADDRESS_NUM-1:0] r_adr2;
   logic                   r_start;
   logic                   r_done;

   logic                   w_last;
   logic [ADDRESS_NUM-1:0] w_base;
   logic [ADDRESS_NUM-1:0] w_adr1;
   logic [ADDRESS_NUM-1:0] w_adr2;

   assign w_last = r_round ? (r_k == LAST_SLIDE) : (r_k == LAST_FULL);
   assign w_base = r_round ? BASE_SLIDE : '0;
   assign w_adr1 = w_base + ADDRESS_NUM'({r_k, 1'b0});
   assign w_adr2 = w_last ? w_adr1 : w_adr1 + ADDRESS_NUM'(1);

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_round <= 1'b0;
         r_new1  <= '0;
         r_new2  <= '0;
         r_adr1  <= '0;
         r_adr2  <= '0;
         r_start <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  r_state <= ST_LOAD;
                  r_round <= i_cmd_round;
                  r_k     <= '0;
               end
            end
            default: begin
               if (i_s_valid) begin
                  r_new1  <= i_s_data[DATA_WIDTH-1:0];
                  // Last beat carries one pixel; duplicate it to the same address.
                  r_new2  <= w_last ? i_s_data[DATA_WIDTH-1:0]
                                    : i_s_data[2*DATA_WIDTH-1:DATA_WIDTH];
                  r_adr1  <= w_adr1;
                  r_adr2  <= w_adr2;
                  r_start <= 1'b1;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end else begin
                     r_k <= r_k + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   assign o_cmd_ready = (r_state == ST_IDLE);
   assign o_s_ready   = (r_state == ST_LOAD);
   assign o_new1      = r_new1;
   assign o_new2      = r_new2;
   assign o_adrs_in1  = r_adr1;
   assign o_adrs_in2  = r_adr2;
   assign o_start     = r_start;
   assign o_round     = r_round;
   assign o_done      = r_done;

endmodule
